// File: rtl/edge_event_arbiter.sv
// Multi-channel rising-edge event scheduler.
// Captures per-channel rising edges as pending flags and drains them one at a time via a round-robin valid/ready port.
module edge_event_arbiter #(
    parameter int N_CH = 4,
    localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sig_in,
    input  logic [N_CH-1:0] en_mask,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [ID_W-1:0] evt_id,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] overflow,
    input  logic            ovf_clr
);

    logic [N_CH-1:0] prev_reg;
    logic [N_CH-1:0] pending_reg;
    logic [N_CH-1:0] pending_next;
    logic [N_CH-1:0] overflow_reg;
    logic [N_CH-1:0] overflow_next;
    logic            evt_valid_reg;
    logic [ID_W-1:0] evt_id_reg;
    logic [ID_W-1:0] rr_ptr_reg;

    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] grant_vec;
    logic            out_free;
    logic            grant_found;
    logic [ID_W-1:0] grant_id;

    assign out_free = ~evt_valid_reg | evt_ready;

    // A channel disabled this cycle is not eligible; its flag is dropped at the edge.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
            assign rise[gi] = sig_in[gi] & ~prev_reg[gi] & en_mask[gi];
            assign req[gi]  = pending_reg[gi] & en_mask[gi];
            assign pending_next[gi] = en_mask[gi]
                                    & (rise[gi] | (pending_reg[gi] & ~grant_vec[gi]));
            assign overflow_next[gi] = (rise[gi] & pending_reg[gi] & ~grant_vec[gi])
                                     | (overflow_reg[gi] & ~ovf_clr);
        end
    endgenerate

    // Search starts one past the last granted channel and wraps.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(rr_ptr_reg) + k) % N_CH;
            if (!grant_found && req[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        if (out_free && grant_found) begin
            grant_vec[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg      <= sig_in;
            pending_reg   <= '0;
            overflow_reg  <= '0;
            evt_valid_reg <= 1'b0;
            evt_id_reg    <= '0;
            rr_ptr_reg    <= ID_W'(N_CH - 1);
        end else begin
            prev_reg     <= sig_in;
            pending_reg  <= pending_next;
            overflow_reg <= overflow_next;
            if (out_free) begin
                evt_valid_reg <= grant_found;
                if (grant_found) begin
                    evt_id_reg <= grant_id;
                    rr_ptr_reg <= grant_id;
                end
            end
        end
    end

    assign evt_valid = evt_valid_reg;
    assign evt_id    = evt_id_reg;
    assign pending   = pending_reg;
    assign overflow  = overflow_reg;

endmodule
